perf_monitor: RTL and testbench

//  Pipeline performance monitor inside CPU. Counts run cycles, hazard stalls,

---
 rtl/perf_monitor.sv | 159 +++++++++++++++
 tb/tb_perf_monitor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
// Pipeline performance monitor: counts RUN cycles, hazard stalls, control
// flushes and retired instructions, halts at a cycle limit, and hands the
// counts out through a held valid/ready snapshot port.
module perf_monitor #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned CYCLE_LIMIT = 80
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             nop_i,
  input  logic             jump_i,
  input  logic             branch_i,
  input  logic             eq_i,
  input  logic             retire_i,
  input  logic             snap_req_i,
  input  logic             snap_ready_i,
  output logic             snap_valid_o,
  output logic [CNT_W-1:0] cycle_o,
  output logic [CNT_W-1:0] stall_o,
  output logic [CNT_W-1:0] flush_o,
  output logic [CNT_W-1:0] retire_o,
  output logic             halt_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(CYCLE_LIMIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] snap_cyc_q, snap_cyc_d;
  logic [CNT_W-1:0] snap_stall_q, snap_stall_d;
  logic [CNT_W-1:0] snap_flush_q, snap_flush_d;
  logic [CNT_W-1:0] snap_ret_q, snap_ret_d;
  logic             snap_valid_q, snap_valid_d;
  logic             halt_q, halt_d;
  logic             halt_edge_c;
  logic             stall_ev_c;
  logic             flush_ev_c;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  assign stall_ev_c = nop_i & ~jump_i & ~branch_i;
  assign flush_ev_c = (branch_i & eq_i) | jump_i;

  // Next-state, counter update and snapshot capture/release.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    stall_d      = stall_q;
    flush_d      = flush_q;
    ret_d        = ret_q;
    snap_cyc_d   = snap_cyc_q;
    snap_stall_d = snap_stall_q;
    snap_flush_d = snap_flush_q;
    snap_ret_d   = snap_ret_q;
    snap_valid_d = snap_valid_q;
    halt_edge_c  = 1'b0;

    if (clear_i) begin
      state_d = ST_IDLE;
      cyc_d   = '0;
      stall_d = '0;
      flush_d = '0;
      ret_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) state_d = ST_RUN;
        end
        ST_RUN: begin
          cyc_d   = sat_inc(cyc_q, 1'b1);
          stall_d = sat_inc(stall_q, stall_ev_c);
          flush_d = sat_inc(flush_q, flush_ev_c);
          ret_d   = sat_inc(ret_q, retire_i);
          // Limit check wins over a simultaneous pause request.
          if ((CYCLE_LIMIT != 0) && (cyc_d == LIMIT)) begin
            state_d     = ST_HALT;
            halt_edge_c = 1'b1;
          end else if (!start_i) begin
            state_d = ST_IDLE;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // A release edge never captures, leaving one idle cycle between snapshots.
    if (snap_valid_q) begin
      if (snap_ready_i) snap_valid_d = 1'b0;
    end else if (snap_req_i || halt_edge_c) begin
      snap_cyc_d   = cyc_d;
      snap_stall_d = stall_d;
      snap_flush_d = flush_d;
      snap_ret_d   = ret_d;
      snap_valid_d = 1'b1;
    end

    halt_d = (state_d == ST_HALT);
  end

  // State, counters and registered snapshot outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cyc_q        <= '0;
      stall_q      <= '0;
      flush_q      <= '0;
      ret_q        <= '0;
      snap_cyc_q   <= '0;
      snap_stall_q <= '0;
      snap_flush_q <= '0;
      snap_ret_q   <= '0;
      snap_valid_q <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
      ret_q        <= ret_d;
      snap_cyc_q   <= snap_cyc_d;
      snap_stall_q <= snap_stall_d;
      snap_flush_q <= snap_flush_d;
      snap_ret_q   <= snap_ret_d;
      snap_valid_q <= snap_valid_d;
      halt_q       <= halt_d;
    end
  end

  assign snap_valid_o = snap_valid_q;
  assign cycle_o      = snap_cyc_q;
  assign stall_o      = snap_stall_q;
  assign flush_o      = snap_flush_q;
  assign retire_o     = snap_ret_q;
  assign halt_o       = halt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Scoreboard bench for perf_monitor: a behavioural model predicts snapshots,
// monitors pop and compare whenever the DUT presents a new snapshot.
module tb_perf_monitor;

  localparam longint MAXV32 = 64'hFFFF_FFFF;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic start_i = 0, clear_i = 0, nop_i = 0, jump_i = 0, branch_i = 0, eq_i = 0;
  logic retire_i = 0, snap_req_i = 0, snap_ready_i = 0;
  logic        snap_valid_o, halt_o;
  logic [31:0] cycle_o, stall_o, flush_o, retire_o;
  logic [1:0]  state_o;

  logic s_start = 0, s_clear = 0, s_retire = 0, s_req = 0, s_ready = 0;
  logic       s_valid, s_halt;
  logic [3:0] s_cycle, s_stall, s_flush, s_ret;
  logic [1:0] s_state;

  int checks = 0;
  int errors = 0;

  perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(80)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
    .nop_i(nop_i), .jump_i(jump_i), .branch_i(branch_i), .eq_i(eq_i),
    .retire_i(retire_i), .snap_req_i(snap_req_i), .snap_ready_i(snap_ready_i),
    .snap_valid_o(snap_valid_o), .cycle_o(cycle_o), .stall_o(stall_o),
    .flush_o(flush_o), .retire_o(retire_o), .halt_o(halt_o), .state_o(state_o)
  );

  perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(0)) u_small (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(s_start), .clear_i(s_clear),
    .nop_i(1'b0), .jump_i(1'b0), .branch_i(1'b0), .eq_i(1'b0),
    .retire_i(s_retire), .snap_req_i(s_req), .snap_ready_i(s_ready),
    .snap_valid_o(s_valid), .cycle_o(s_cycle), .stall_o(s_stall),
    .flush_o(s_flush), .retire_o(s_ret), .halt_o(s_halt), .state_o(s_state)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    longint c;
    longint s;
    longint f;
    longint r;
  } snap_t;

  snap_t exp_q[$];
  snap_t exp2_q[$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 running, 2 halted.
  int     m_mode = 0;
  longint m_cyc = 0, m_stall = 0, m_flush = 0, m_ret = 0;
  bit     m_valid = 0;
  bit     m_halt_now;

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_mode = 0; m_cyc = 0; m_stall = 0; m_flush = 0; m_ret = 0;
      m_valid = 0;
      exp_q.delete();
    end else begin
      m_halt_now = 0;
      if (clear_i) begin
        m_mode = 0; m_cyc = 0; m_stall = 0; m_flush = 0; m_ret = 0;
      end else if (m_mode == 1) begin
        m_cyc   = sat(m_cyc + 1, MAXV32);
        if (nop_i && !jump_i && !branch_i) m_stall = sat(m_stall + 1, MAXV32);
        if ((branch_i && eq_i) || jump_i) m_flush = sat(m_flush + 1, MAXV32);
        if (retire_i) m_ret = sat(m_ret + 1, MAXV32);
        if (m_cyc == 80) begin
          m_mode = 2;
          m_halt_now = 1;
        end else if (!start_i) begin
          m_mode = 0;
        end
      end else if (m_mode == 0 && start_i) begin
        m_mode = 1;
      end
      if (m_valid) begin
        if (snap_ready_i) m_valid = 0;
      end else if (snap_req_i || m_halt_now) begin
        exp_q.push_back('{m_cyc, m_stall, m_flush, m_ret});
        m_valid = 1;
      end
    end
  end

  // Main monitor: state tracking, snapshot pop on presentation, hold stability.
  logic         prev_v = 0;
  logic [127:0] held = '0;
  always @(negedge clk_i) begin
    snap_t e;
    if (!rst_i) begin
      check("state", state_o, m_mode);
      check("halt", halt_o, (m_mode == 2));
      check("valid", snap_valid_o, m_valid);
      if (snap_valid_o && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_snapshot actual=1 expected=0");
        end else begin
          e = exp_q.pop_front();
          check("snap_cycle", cycle_o, e.c);
          check("snap_stall", stall_o, e.s);
          check("snap_flush", flush_o, e.f);
          check("snap_retire", retire_o, e.r);
        end
        held = {cycle_o, stall_o, flush_o, retire_o};
      end else if (snap_valid_o && prev_v) begin
        check("snap_hold", {cycle_o, stall_o, flush_o, retire_o}, held);
      end
    end
    prev_v = snap_valid_o;
  end

  // Small-width monitor.
  logic s_prev = 0;
  int   s_seen = 0;
  always @(negedge clk_i) begin
    snap_t e;
    if (!rst_i && s_valid && !s_prev) begin
      s_seen++;
      if (exp2_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL small_unexpected_snapshot actual=1 expected=0");
      end else begin
        e = exp2_q.pop_front();
        check("small_cycle", s_cycle, e.c);
        check("small_stall", s_stall, e.s);
        check("small_flush", s_flush, e.f);
        check("small_retire", s_ret, e.r);
      end
    end
    s_prev = s_valid;
  end

  // Apply one cycle of inputs, returning at the following negedge.
  task automatic drive(input bit st, input bit cl, input bit n, input bit j,
                       input bit b, input bit e, input bit rt, input bit rq,
                       input bit rd);
    start_i = st; clear_i = cl; nop_i = n; jump_i = j; branch_i = b; eq_i = e;
    retire_i = rt; snap_req_i = rq; snap_ready_i = rd;
    @(negedge clk_i);
  endtask

  task automatic release_snap();
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("released", snap_valid_o, 1'b0);
  endtask

  task automatic clear_run();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all(input string nm, input longint c, input longint s,
                           input longint f, input longint r);
    check({nm, "_valid"}, snap_valid_o, 1'b1);
    check({nm, "_cycle"}, cycle_o, c);
    check({nm, "_stall"}, stall_o, s);
    check({nm, "_flush"}, flush_o, f);
    check({nm, "_retire"}, retire_o, r);
  endtask

  initial begin
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_state", state_o, 2'b00);
    check("rst_outputs", {snap_valid_o, halt_o, cycle_o, stall_o, flush_o, retire_o}, '0);
    rst_i = 1'b0;

    // Free run to the cycle limit with auto-capture.
    repeat (81) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_halt", halt_o, 1'b1);
    check("t1_state", state_o, 2'b10);
    check_all("t1", 80, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1'($urandom), 0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_still_halt", state_o, 2'b10);
    release_snap();

    // Stalls then jump-flushes.
    clear_run();
    repeat (3) drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) drive(1, 0, 1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    check_all("t2", 6, 3, 2, 0);
    release_snap();

    // Untaken branches then taken branch with bubble.
    clear_run();
    repeat (4) drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 1, 1, 0, 1, 0);
    check_all("t3", 5, 0, 1, 0);
    release_snap();

    // Request in the 10th run cycle, held while not ready.
    clear_run();
    repeat (9) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    check_all("t4", 10, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
      check("t4_hold_cycle", cycle_o, 32'd10);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
    check("t4_release", snap_valid_o, 1'b0);
    release_snap();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++)
      drive(($urandom % 8) != 0, ($urandom % 60) == 0, 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), ($urandom % 6) == 0,
            ($urandom % 3) == 0);
    release_snap();

    // Asynchronous reset between edges.
    clear_run();
    repeat (5) drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    snap_req_i = 1'b1;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("t6_async_rst", {snap_valid_o, halt_o, state_o, cycle_o, stall_o, flush_o, retire_o}, '0);
    #1 rst_i = 1'b0;
    snap_req_i = 1'b0;
    @(negedge clk_i);
    repeat (81) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_halt", halt_o, 1'b1);
    check_all("t6_final", 80, 0, 0, 0);
    release_snap();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("t6_clear_state", state_o, 2'b00);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check_all("t6_zero", 0, 0, 0, 0);
    release_snap();

    // Narrow counters saturate without halting.
    exp2_q.push_back('{15, 0, 0, 15});
    s_start = 1; s_retire = 1;
    repeat (21) @(negedge clk_i);
    s_req = 1;
    @(negedge clk_i);
    s_req = 0;
    check("t5_no_halt", s_halt, 1'b0);
    check("t5_state", s_state, 2'b01);
    check("t5_cycle", s_cycle, 4'd15);
    check("t5_retire", s_ret, 4'd15);
    repeat (3) @(negedge clk_i);
    check("t5_seen", s_seen, 1);
    check("pending_snapshots", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
